pattern_sequencer: RTL and testbench
====================================

Name: pattern_sequencer

Overview:
- Drives the 4-bit pattern select input of the VGA test pattern generator.
- Accepts manual next/prev/load requests and an optional auto-cycle mode.
- Every pattern change is deferred to a frame boundary (end of active video), so a frame never shows mixed patterns.
- Sits between the board button/switch logic (already debounced to single-cycle pulses) and the pattern generator, fed by the same VSync as the generator.

Parameters:
NUM_PATTERNS, 7, number of valid patterns (0..NUM_PATTERNS-1); range 2..16
RESET_PATTERN, 1, o_Pattern value after reset; must be < NUM_PATTERNS
DWELL_FRAMES, 60, frames each pattern is shown in auto mode; range 1..255

Ports:
i_Clk  in  1  pixel clock
i_Reset  in  1  asynchronous, active-high reset
i_VSync  in  1  high during active rows, low during vertical blanking
i_Next  in  1  single-cycle pulse: advance target pattern by one
i_Prev  in  1  single-cycle pulse: step target pattern back by one
i_Load  in  1  single-cycle pulse: set target to i_Load_Value
i_Load_Value  in  4  pattern index used with i_Load
i_Auto_En  in  1  level: enables auto-cycling
o_Pattern  out  4  registered pattern select to the generator
o_Pending  out  1  a manual request is waiting for the next boundary
o_Frame_Tick  out  1  single-cycle pulse on each frame boundary

Behaviour:
- Reset (async assert, sync use):
  - o_Pattern=RESET_PATTERN, r_Target=RESET_PATTERN, o_Pending=0, o_Frame_Tick=0.
  - Frame counter=0; r_VSync_d=0; state=S_IDLE.
- Boundary:
  - w_Boundary = r_VSync_d & ~i_VSync (falling edge, start of blanking).
  - On the edge where i_VSync is first sampled low, o_Frame_Tick<=1 and o_Pattern<=next-target, both visible the following cycle.
  - Latency from VSync fall to new o_Pattern: 1 clock.
- Requests are evaluated every cycle and update r_Target. Priority: i_Load > (i_Next xor i_Prev).
  - i_Next and i_Prev in the same cycle: no change.
  - Next: (r_Target==NUM_PATTERNS-1) ? 0 : r_Target+1.
  - Prev: (r_Target==0) ? NUM_PATTERNS-1 : r_Target-1.
  - Load with i_Load_Value >= NUM_PATTERNS: ignored entirely. No target change, no pending.
  - Multiple requests before one boundary accumulate in r_Target; only the final value is applied.
- FSM:
  - S_IDLE: r_Target==o_Pattern, o_Pending=0.
    - Accepted request -> S_PENDING.
    - Boundary with auto firing -> stay in S_IDLE.
  - S_PENDING: o_Pending=1.
    - On boundary: o_Pattern<=r_Target (or the request result of that same cycle), frame counter<=0, -> S_IDLE.
    - A net-zero sequence (Next then Prev) still stays pending; it is applied as a no-change and resets the counter.
- Request on the boundary cycle itself:
  - The request is folded into r_Target first, and that result is applied on that edge.
  - State -> S_IDLE, o_Pending=0.
- Auto mode (i_Auto_En=1):
  - The frame counter increments on each boundary while in S_IDLE.
  - At a boundary with counter==DWELL_FRAMES-1:
    - Target advances, skipping pattern 0: (t==NUM_PATTERNS-1 or t==0) ? 1 : t+1.
    - Target is applied immediately; counter<=0.
  - A manual request pending at that boundary overrides the auto step.
  - i_Auto_En=0: counter held at 0, no auto steps.
  - Re-enabling restarts the dwell from 0.
- Width rules:
  - Frame counter is 8 bits.
  - All compares are unsigned 4-bit, zero-extended parameters.
- Reset asserted mid-frame or mid-pending: everything returns to reset values immediately, and the pending request is discarded.
  - After release, no boundary is detected until i_VSync has been sampled high and then low.
- o_Pattern changes only on boundary edges or on reset. No other cycle may change it.

Test Plan:
- Reset with i_VSync low, release, pulse i_Next at mid-frame -> o_Pattern stays 1 and o_Pending=1 until VSync fall; o_Pattern=2 exactly 1 clock after the fall; o_Pending=0.
- o_Pattern=6 (NUM_PATTERNS=7): i_Next -> 0 at boundary. Then i_Prev twice in one frame -> 5 at the next boundary.
- Same-cycle i_Next+i_Prev -> no pending, o_Pattern unchanged. i_Load with value 9 -> ignored. i_Load 4 together with i_Next -> 4 applied.
- DWELL_FRAMES=3, auto on from pattern 6 -> sequence 6,1,2 with changes at every 3rd o_Frame_Tick; pattern 0 is never shown.
- Auto on with counter=2 (DWELL_FRAMES=3); i_Load 4 before the boundary -> 4 applied instead of the auto step, counter=0, next auto step 3 frames later to 5.
- Assert i_Reset while o_Pending=1 with target 3 -> o_Pattern=1 and o_Pending=0 asynchronously; the following boundary keeps 1.

Source files
------------

// File: rtl/pattern_sequencer.sv
// Frame-synchronous pattern selector for the VGA test pattern generator.
// Manual next/prev/load requests and auto-cycling take effect only at VSync fall.
module pattern_sequencer #(
    parameter int NUM_PATTERNS  = 7,
    parameter int RESET_PATTERN = 1,
    parameter int DWELL_FRAMES  = 60
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_VSync,
    input  logic       i_Next,
    input  logic       i_Prev,
    input  logic       i_Load,
    input  logic [3:0] i_Load_Value,
    input  logic       i_Auto_En,
    output logic [3:0] o_Pattern,
    output logic       o_Pending,
    output logic       o_Frame_Tick
);

    localparam logic [3:0] c_Last       = 4'(NUM_PATTERNS - 1);
    localparam logic [3:0] c_Reset      = 4'(RESET_PATTERN);
    localparam logic [4:0] c_Num        = 5'(NUM_PATTERNS);
    localparam logic [7:0] c_Dwell_Last = 8'(DWELL_FRAMES - 1);

    typedef enum logic {S_IDLE, S_PENDING} state_t;

    state_t     r_State;
    logic [3:0] r_Target;
    logic [7:0] r_Frame_Cnt;
    logic       r_VSync_d;

    logic       w_Boundary;
    logic       w_Load_Ok;
    logic       w_Accept;
    logic [3:0] w_Req_Target;
    logic [3:0] w_Auto_Target;

    assign w_Boundary = r_VSync_d & ~i_VSync;
    assign w_Load_Ok  = i_Load & ({1'b0, i_Load_Value} < c_Num);

    // Auto-cycling never lands on pattern 0.
    assign w_Auto_Target = (r_Target == c_Last || r_Target == 4'd0) ? 4'd1 : r_Target + 4'd1;

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        w_Req_Target = r_Target;
        w_Accept     = 1'b0;
        if (w_Load_Ok) begin
            w_Req_Target = i_Load_Value;
            w_Accept     = 1'b1;
        end else if (i_Next ^ i_Prev) begin
            w_Accept = 1'b1;
            if (i_Next)
                w_Req_Target = (r_Target == c_Last) ? 4'd0 : r_Target + 4'd1;
            else
                w_Req_Target = (r_Target == 4'd0) ? c_Last : r_Target - 4'd1;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_State      <= S_IDLE;
            r_Target     <= c_Reset;
            r_Frame_Cnt  <= 8'd0;
            r_VSync_d    <= 1'b0;
            o_Pattern    <= c_Reset;
            o_Pending    <= 1'b0;
            o_Frame_Tick <= 1'b0;
        end else begin
            r_VSync_d    <= i_VSync;
            o_Frame_Tick <= w_Boundary;

            if (w_Boundary) begin
                if (r_State == S_PENDING || w_Accept) begin
                    // A request folded in on the boundary cycle itself is applied right away.
                    o_Pattern   <= w_Req_Target;
                    r_Target    <= w_Req_Target;
                    r_Frame_Cnt <= 8'd0;
                    r_State     <= S_IDLE;
                    o_Pending   <= 1'b0;
                end else if (i_Auto_En) begin
                    if (r_Frame_Cnt == c_Dwell_Last) begin
                        o_Pattern   <= w_Auto_Target;
                        r_Target    <= w_Auto_Target;
                        r_Frame_Cnt <= 8'd0;
                    end else begin
                        r_Frame_Cnt <= r_Frame_Cnt + 8'd1;
                    end
                end else begin
                    r_Frame_Cnt <= 8'd0;
                end
            end else begin
                if (w_Accept) begin
                    r_Target  <= w_Req_Target;
                    r_State   <= S_PENDING;
                    o_Pending <= 1'b1;
                end
                if (!i_Auto_En)
                    r_Frame_Cnt <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench for pattern_sequencer: directed scenarios plus randomized
// request traffic compared against a frame-level behavioural model.
module tb_pattern_sequencer;

    localparam int N = 7;
    localparam int R = 1;
    localparam int D = 3;

    logic       i_Clk = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_VSync = 1'b0;
    logic       i_Next = 1'b0;
    logic       i_Prev = 1'b0;
    logic       i_Load = 1'b0;
    logic [3:0] i_Load_Value = 4'd0;
    logic       i_Auto_En = 1'b0;
    logic [3:0] o_Pattern;
    logic       o_Pending;
    logic       o_Frame_Tick;

    always #5 i_Clk = ~i_Clk;

    pattern_sequencer #(
        .NUM_PATTERNS (N),
        .RESET_PATTERN(R),
        .DWELL_FRAMES (D)
    ) dut (
        .i_Clk       (i_Clk),
        .i_Reset     (i_Reset),
        .i_VSync     (i_VSync),
        .i_Next      (i_Next),
        .i_Prev      (i_Prev),
        .i_Load      (i_Load),
        .i_Load_Value(i_Load_Value),
        .i_Auto_En   (i_Auto_En),
        .o_Pattern   (o_Pattern),
        .o_Pending   (o_Pending),
        .o_Frame_Tick(o_Frame_Tick)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: displayed pattern, requested pattern, dwell count in frames.
    int m_pat, m_tgt, m_cnt;
    bit m_pend, m_tick, m_vsd;

    task automatic model_reset();
        m_pat = R; m_tgt = R; m_cnt = 0; m_pend = 0; m_tick = 0; m_vsd = 0;
    endtask

    // One clock with the given request pulses; the model advances alongside.
    task automatic step(input bit nx, input bit pv, input bit ld, input logic [3:0] lv);
        bit bnd;
        i_Next = nx; i_Prev = pv; i_Load = ld; i_Load_Value = lv;
        bnd = m_vsd && !i_VSync;
        if (ld && int'(lv) < N) begin
            m_tgt = lv; m_pend = 1;
        end else if (nx != pv) begin
            m_tgt = nx ? (m_tgt + 1) % N : (m_tgt + N - 1) % N;
            m_pend = 1;
        end
        if (bnd) begin
            if (m_pend) begin
                m_pat = m_tgt; m_cnt = 0; m_pend = 0;
            end else if (i_Auto_En) begin
                if (m_cnt == D - 1) begin
                    m_tgt = m_tgt % (N - 1) + 1; m_pat = m_tgt; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
        if (!i_Auto_En) m_cnt = 0;
        m_tick = bnd;
        m_vsd = i_VSync;
        @(negedge i_Clk);
        i_Next = 0; i_Prev = 0; i_Load = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 4'd0);
    endtask

    // Active rows then blanking; the first blanking cycle is the boundary.
    task automatic frame(input int active, input int blank);
        i_VSync = 1; idle(active);
        i_VSync = 0; idle(blank);
    endtask

    task automatic do_reset();
        i_Reset = 1; i_VSync = 0; i_Auto_En = 0;
        repeat (2) @(negedge i_Clk);
        i_Reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_Pattern !== 4'd1) begin errors++; $display("FAIL reset_pattern: got %0d expected 1", o_Pattern); end
        checks++; if (o_Pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %0b expected 0", o_Pending); end
        checks++; if (o_Frame_Tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %0b expected 0", o_Frame_Tick); end
    endtask

    task automatic test_next_deferred();
        i_VSync = 1; idle(3);
        step(1, 0, 0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_Pattern !== 4'd1 || o_Pending !== 1'b1) begin
                errors++; $display("FAIL next_held: pattern %0d pending %0b expected 1/1", o_Pattern, o_Pending);
            end
            step(0, 0, 0, 4'd0);
        end
        i_VSync = 0; step(0, 0, 0, 4'd0);
        checks++;
        if (o_Pattern !== 4'd2 || o_Pending !== 1'b0 || o_Frame_Tick !== 1'b1) begin
            errors++; $display("FAIL next_applied: pattern %0d pending %0b tick %0b expected 2/0/1", o_Pattern, o_Pending, o_Frame_Tick);
        end
        step(0, 0, 0, 4'd0);
        checks++; if (o_Frame_Tick !== 1'b0) begin errors++; $display("FAIL tick_width: got %0b expected 0", o_Frame_Tick); end
    endtask

    task automatic test_wrap();
        i_VSync = 1; idle(2); step(0, 0, 1, 4'd6); idle(2);
        i_VSync = 0; idle(2);
        checks++; if (o_Pattern !== 4'd6) begin errors++; $display("FAIL load6: got %0d expected 6", o_Pattern); end
        i_VSync = 1; idle(2); step(1, 0, 0, 4'd0); idle(2);
        i_VSync = 0; idle(2);
        checks++; if (o_Pattern !== 4'd0) begin errors++; $display("FAIL wrap_up: got %0d expected 0", o_Pattern); end
        i_VSync = 1; idle(1); step(0, 1, 0, 4'd0); idle(1); step(0, 1, 0, 4'd0); idle(2);
        checks++; if (o_Pattern !== 4'd0) begin errors++; $display("FAIL wrap_hold: got %0d expected 0", o_Pattern); end
        i_VSync = 0; idle(2);
        checks++; if (o_Pattern !== 4'd5) begin errors++; $display("FAIL wrap_down: got %0d expected 5", o_Pattern); end
    endtask

    task automatic test_conflicts();
        i_VSync = 1; idle(2);
        step(1, 1, 0, 4'd0);
        checks++; if (o_Pending !== 1'b0) begin errors++; $display("FAIL next_prev_pending: got %0b expected 0", o_Pending); end
        step(0, 0, 1, 4'd9);
        checks++; if (o_Pending !== 1'b0) begin errors++; $display("FAIL bad_load_pending: got %0b expected 0", o_Pending); end
        i_VSync = 0; idle(2);
        checks++; if (o_Pattern !== 4'd5) begin errors++; $display("FAIL ignored_requests: got %0d expected 5", o_Pattern); end
        i_VSync = 1; idle(2); step(1, 0, 1, 4'd4); idle(2);
        i_VSync = 0; idle(2);
        checks++; if (o_Pattern !== 4'd4) begin errors++; $display("FAIL load_priority: got %0d expected 4", o_Pattern); end
        // Request on the boundary cycle is applied on that same edge.
        i_VSync = 1; idle(3);
        i_VSync = 0; step(0, 1, 0, 4'd0);
        checks++;
        if (o_Pattern !== 4'd3 || o_Pending !== 1'b0) begin
            errors++; $display("FAIL boundary_request: pattern %0d pending %0b expected 3/0", o_Pattern, o_Pending);
        end
        idle(1);
    endtask

    task automatic test_auto();
        int exp_seq[6] = '{6, 6, 1, 1, 1, 2};
        i_VSync = 1; idle(2); step(0, 0, 1, 4'd6); idle(1);
        i_VSync = 0; idle(2);
        i_Auto_En = 1;
        for (int f = 0; f < 6; f++) begin
            i_VSync = 1; idle(4);
            i_VSync = 0; step(0, 0, 0, 4'd0);
            checks++;
            if (o_Pattern !== 4'(exp_seq[f]) || o_Frame_Tick !== 1'b1) begin
                errors++; $display("FAIL auto_seq[%0d]: pattern %0d tick %0b expected %0d/1", f, o_Pattern, o_Frame_Tick, exp_seq[f]);
            end
            idle(1);
        end
    endtask

    task automatic test_auto_override();
        int exp_seq[3] = '{4, 4, 5};
        i_Auto_En = 0;
        i_VSync = 1; idle(2); step(0, 0, 1, 4'd1); idle(1);
        i_VSync = 0; idle(2);
        i_Auto_En = 1;
        frame(4, 2); frame(4, 2);
        i_VSync = 1; idle(2); step(0, 0, 1, 4'd4); idle(2);
        i_VSync = 0; idle(2);
        checks++; if (o_Pattern !== 4'd4) begin errors++; $display("FAIL auto_override: got %0d expected 4", o_Pattern); end
        for (int f = 0; f < 3; f++) begin
            frame(4, 2);
            checks++;
            if (o_Pattern !== 4'(exp_seq[f])) begin
                errors++; $display("FAIL override_dwell[%0d]: got %0d expected %0d", f, o_Pattern, exp_seq[f]);
            end
        end
        i_Auto_En = 0;
    endtask

    task automatic test_reset_pending();
        i_VSync = 1; idle(2); step(0, 0, 1, 4'd3); idle(1);
        checks++; if (o_Pending !== 1'b1) begin errors++; $display("FAIL pre_reset_pending: got %0b expected 1", o_Pending); end
        #2 i_Reset = 1;
        #1;
        checks++;
        if (o_Pattern !== 4'd1 || o_Pending !== 1'b0) begin
            errors++; $display("FAIL async_reset: pattern %0d pending %0b expected 1/0", o_Pattern, o_Pending);
        end
        @(negedge i_Clk);
        i_Reset = 0; i_VSync = 0;
        model_reset();
        idle(2);
        checks++; if (o_Frame_Tick !== 1'b0) begin errors++; $display("FAIL no_boundary_after_reset: got %0b expected 0", o_Frame_Tick); end
        frame(3, 2);
        checks++; if (o_Pattern !== 4'd1) begin errors++; $display("FAIL reset_discards: got %0d expected 1", o_Pattern); end
    endtask

    task automatic test_random();
        do_reset();
        for (int f = 0; f < 40; f++) begin
            int active, blank;
            i_Auto_En = ($urandom_range(0, 3) != 0);
            active = $urandom_range(3, 10);
            blank  = $urandom_range(1, 4);
            for (int c = 0; c < active + blank; c++) begin
                int r;
                bit nx, pv, ld;
                logic [3:0] lv;
                i_VSync = (c < active);
                r  = $urandom_range(0, 15);
                nx = 0; pv = 0; ld = 0;
                lv = 4'($urandom_range(0, 15));
                if (r == 0) begin
                    ld = 1;
                    if (int'(lv) < N) begin nx = 1'($urandom); pv = 1'($urandom); end
                end else if (r == 1) nx = 1;
                else if (r == 2) pv = 1;
                else if (r == 3) begin nx = 1; pv = 1; end
                step(nx, pv, ld, lv);
                checks++;
                if (o_Pattern !== 4'(m_pat) || o_Pending !== m_pend || o_Frame_Tick !== m_tick) begin
                    errors++;
                    $display("FAIL random f%0d c%0d: pattern %0d pending %0b tick %0b expected %0d/%0b/%0b",
                             f, c, o_Pattern, o_Pending, o_Frame_Tick, m_pat, m_pend, m_tick);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_next_deferred();
        test_wrap();
        test_conflicts();
        test_auto();
        test_auto_override();
        test_reset_pending();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
